matrix_result_serializer: RTL and testbench
===========================================

Name: matrix_result_serializer

Overview:
- Output stage of the 3x3 matrix-multiply pipeline; sits directly downstream of the matrix multiply core.
- Captures the nine 18-bit result elements into a shadow register when started.
- Streams them as bytes over the 8-bit dedicated output bus with a valid/ready handshake.
- Signals completion back to the top-level sequencer.

Parameters:
- N_ELEM, 9, number of result elements streamed (row-major, element 0 first).
- ELEM_W, 18, width of each result element.
- BYTES_PER_ELEM (localparam), ceil(ELEM_W/8) = 3, bytes emitted per element.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level from sequencer (high while in the output phase).
- c_flat  in  N_ELEM*ELEM_W (162)  results; element i = c_flat[i*ELEM_W +: ELEM_W].
- out_ready  in  1  downstream accepts the current byte; top tie-high allowed.
- out_data  out  8  current byte.
- out_valid  out  1  out_data holds a valid byte.
- done  out  1  whole matrix transferred.

Behaviour:
- Reset (rst high at an edge): state IDLE; out_data=8'h00, out_valid=0, done=0; element/byte counters=0; shadow register=0.
- rst has priority over all other inputs. Asserting it mid-stream aborts the transfer; the next start restarts from element 0, byte 0.
- States: IDLE, SEND, DONE.
- IDLE -> SEND: start=1 sampled at edge k.
  - c_flat is copied into the shadow register at edge k.
  - After edge k: out_valid=1 and out_data = byte 0 of element 0 (one-cycle latency from start).
- Byte order:
  - Elements 0..N_ELEM-1 in order.
  - Within an element, most-significant byte first; the element is zero-extended to 24 bits.
  - For ELEM_W=18: byte0={6'b0,C[17:16]}, byte1=C[15:8], byte2=C[7:0].
- Handshake: a transfer occurs at an edge where out_valid=1 and out_ready=1.
  - After each transfer, the next byte is presented in the following cycle with no bubble.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Counters:
  - The byte counter wraps 2->0 and increments the element counter.
  - The transfer of element N_ELEM-1, byte 2 is the final transfer.
- SEND -> DONE: on the final transfer edge.
  - After that edge: out_valid=0, out_data=8'h00, done=1.
- DONE:
  - done stays 1 while start=1.
  - The first edge with start=0 returns to IDLE with done=0.
  - The top sequencer drops start one cycle after seeing done, so done is high for at least one cycle.
- Ignored inputs:
  - start re-assertion or toggling during SEND is ignored.
  - Changes on c_flat during SEND or DONE do not affect the stream (shadow copy only).
- With out_ready tied high: exactly N_ELEM*BYTES_PER_ELEM = 27 consecutive valid cycles, then done.
- Total bytes per run: 27. No header, no checksum.
- Unsigned arithmetic only. Counter widths: element 4 bits, byte 2 bits.
- Expected size: 150–250 lines of RTL.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 for 10 cycles -> out_valid=0, done=0, out_data=00 throughout.
- Basic stream, ready tied high: C[i]=i+1, start held -> out_valid rises 1 cycle after start and stays high for 27 consecutive cycles. Bytes are 00 00 01, 00 00 02, ..., 00 00 09. Then done=1; done clears 1 cycle after start=0.
- Max values and zero padding: C[0]=18'h3FFFF, C[8]=18'h20001, others 0 -> first three bytes 03 FF FF; last three bytes 02 00 01.
- Backpressure: out_ready low for 5 cycles on byte 4, then high -> byte 4 value held stable for all 6 cycles with out_valid=1. No byte is lost or duplicated; 27 transfers in total.
- Shadow isolation: c_flat changes every cycle during SEND, start toggled mid-stream -> the emitted stream equals the values captured at the start edge; no restart occurs.
- Reset mid-operation: rst pulsed after the 10th transfer -> out_valid=0 the next cycle. A new start re-emits from element 0, byte 0; all 27 bytes are correct.

Source files
------------

// File: rtl/matrix_result_serializer.sv
// ---------------------------------------------------------------------------
// matrix_result_serializer
//
// Output stage of the 3x3 matrix-multiply pipeline. When the sequencer raises
// start, the nine result elements are frozen into a shadow register. They are
// then streamed over an 8-bit valid/ready bus in row-major order. Each element
// is zero-extended to a whole number of bytes and sent most-significant byte
// first. When the last byte has been accepted, done is raised and held until
// start drops.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        synchronous active-high reset (priority over everything)
//   start      level from sequencer, high during the output phase
//   c_flat     N_ELEM*ELEM_W result bus, element i at [i*ELEM_W +: ELEM_W]
//   out_ready  downstream accepts the current byte
//   out_data   current byte (8'h00 when not valid)
//   out_valid  out_data holds a valid byte
//   done       whole matrix transferred
// ---------------------------------------------------------------------------
module matrix_result_serializer #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_ELEM*ELEM_W-1:0]   c_flat,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  output logic                       done
);

  localparam int BYTES_PER_ELEM = (ELEM_W + 7) / 8;
  localparam int PAD_W          = BYTES_PER_ELEM * 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAST_ELEM = 4'(N_ELEM - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_ELEM - 1);

  logic [1:0]               state_q,  state_d;
  logic [3:0]               elem_q,   elem_d;
  logic [1:0]               byte_q,   byte_d;
  logic [N_ELEM*ELEM_W-1:0] shadow_q, shadow_d;

  logic [ELEM_W-1:0] cur_elem;
  logic [PAD_W-1:0]  cur_padded;
  logic [7:0]        cur_byte;
  logic              xfer;

  // Pick the element addressed by the element counter out of the shadow copy,
  // zero-extend it, then pick the byte addressed by the byte counter with
  // byte 0 being the most significant one.
  always_comb begin
    cur_elem = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (elem_q == 4'(i)) begin
        cur_elem = shadow_q[i*ELEM_W +: ELEM_W];
      end
    end
    cur_padded = PAD_W'(cur_elem);
    cur_byte   = 8'h00;
    for (int b = 0; b < BYTES_PER_ELEM; b++) begin
      if (byte_q == 2'(b)) begin
        cur_byte = cur_padded[(BYTES_PER_ELEM-1-b)*8 +: 8];
      end
    end
  end

  // Outputs are decoded straight from the state so that valid rises exactly
  // one cycle after start is sampled and the bus reads 8'h00 when idle.
  always_comb begin
    out_valid = (state_q == ST_SEND);
    done      = (state_q == ST_DONE);
    out_data  = out_valid ? cur_byte : 8'h00;
    xfer      = out_valid && out_ready;
  end

  // Next-state logic. The shadow register is only loaded on the IDLE->SEND
  // edge, which isolates the stream from later c_flat changes and from
  // start toggling while a transfer is in flight.
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEND;
          shadow_d = c_flat;
          elem_d   = 4'd0;
          byte_d   = 2'd0;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (byte_q == LAST_BYTE) begin
            byte_d = 2'd0;
            if (elem_q == LAST_ELEM) begin
              elem_d  = 4'd0;
              state_d = ST_DONE;
            end else begin
              elem_d = elem_q + 4'd1;
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        elem_d  = 4'd0;
        byte_d  = 2'd0;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-stream simply drops
  // back to IDLE so the next start replays from element 0, byte 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      elem_q   <= 4'd0;
      byte_q   <= 2'd0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_serializer
//
// Self-checking bench for matrix_result_serializer. The expected byte stream
// is computed from the captured matrix with plain shifts and masks into a
// queue, and compared against the bus every cycle.
// ---------------------------------------------------------------------------
module tb_matrix_result_serializer;

  localparam int N_ELEM = 9;
  localparam int ELEM_W = 18;
  localparam int MAT_W  = N_ELEM * ELEM_W;
  localparam int TOTAL  = 27;

  logic             clk;
  logic             rst;
  logic             start;
  logic [MAT_W-1:0] c_flat;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             done;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];

  matrix_result_serializer #(
    .N_ELEM(N_ELEM),
    .ELEM_W(ELEM_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .c_flat   (c_flat),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .done     (done)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts a failure and reports it
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive the DUT inputs (called just after a rising edge)
  task automatic applyStimulus(input logic st, input logic rdy, input logic [MAT_W-1:0] cf);
    start     = st;
    out_ready = rdy;
    c_flat    = cf;
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: element i, zero-extended to 24 bits, MSB first
  task automatic buildExpected(input logic [MAT_W-1:0] mat);
    int v;
    exp_q.delete();
    for (int i = 0; i < N_ELEM; i++) begin
      v = int'(mat[i*ELEM_W +: ELEM_W]);
      exp_q.push_back(8'((v >> 16) & 255));
      exp_q.push_back(8'((v >> 8) & 255));
      exp_q.push_back(8'(v & 255));
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done"},  32'(done),      32'd0);
    checkOutput({tag, "_data"},  32'(out_data),  32'd0);
  endtask

  // Run one transfer of matrix mat.
  //   ready_mode 0: ready tied high; 1: stall 5 cycles on byte 4; 2: random
  //   scramble:    randomise c_flat and toggle start during SEND
  //   abort_at:    pulse reset after that many transfers (-1 = never)
  task automatic runStream(input string tag, input logic [MAT_W-1:0] mat,
                           input int ready_mode, input bit scramble, input int abort_at);
    int idx;
    int cycles;
    int stalled;
    logic rdy;
    logic st;
    logic [MAT_W-1:0] cf;
    buildExpected(mat);
    checkIdle({tag, "_pre"});
    applyStimulus(1'b1, 1'b1, mat);
    step();
    idx     = 0;
    cycles  = 0;
    stalled = 0;
    while (idx < TOTAL && cycles < 400) begin
      if (idx == abort_at) begin
        rst = 1'b1;
        step();
        checkIdle({tag, "_abort"});
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, mat);
        step();
        checkIdle({tag, "_abort_idle"});
        return;
      end
      checkOutput($sformatf("%s_valid_b%0d", tag, idx), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s_data_b%0d", tag, idx),  32'(out_data),  32'(exp_q[idx]));
      checkOutput($sformatf("%s_done_b%0d", tag, idx),  32'(done),      32'd0);
      rdy = 1'b1;
      if (ready_mode == 1 && idx == 4 && stalled < 5) begin
        rdy = 1'b0;
        stalled++;
      end else if (ready_mode == 2) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      st = 1'b1;
      cf = mat;
      if (scramble) begin
        st = 1'($urandom_range(0, 1));
        for (int i = 0; i < N_ELEM; i++) cf[i*ELEM_W +: ELEM_W] = 18'($urandom);
      end
      applyStimulus(st, rdy, cf);
      step();
      if (rdy) idx++;
      cycles++;
    end
    checkOutput({tag, "_transfers"}, 32'(idx), 32'(TOTAL));
    if (ready_mode == 0) checkOutput({tag, "_cycles"}, 32'(cycles), 32'(TOTAL));
    if (ready_mode == 1) checkOutput({tag, "_cycles"}, 32'(cycles), 32'(TOTAL + 5));
    checkOutput({tag, "_done"},     32'(done),      32'd1);
    checkOutput({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_end_data"},  32'(out_data),  32'd0);
    applyStimulus(1'b1, 1'b1, mat);
    step();
    checkOutput({tag, "_done_hold"}, 32'(done), 32'd1);
    checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, mat);
    step();
    checkIdle({tag, "_after"});
  endtask

  function automatic logic [MAT_W-1:0] randomMatrix();
    logic [MAT_W-1:0] m;
    for (int i = 0; i < N_ELEM; i++) m[i*ELEM_W +: ELEM_W] = 18'($urandom);
    return m;
  endfunction

  // Directed sequence of scenarios
  initial begin
    logic [MAT_W-1:0] mat;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, '0);
    step();
    step();
    checkIdle("reset");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, randomMatrix());
      step();
      checkIdle($sformatf("idle_c%0d", c));
    end

    // Basic stream: C[i] = i+1
    mat = '0;
    for (int i = 0; i < N_ELEM; i++) mat[i*ELEM_W +: ELEM_W] = 18'(i + 1);
    runStream("basic", mat, 0, 1'b0, -1);

    // Max value and zero-padding checks
    mat = '0;
    mat[0 +: ELEM_W]          = 18'h3FFFF;
    mat[8*ELEM_W +: ELEM_W]   = 18'h20001;
    runStream("maxval", mat, 0, 1'b0, -1);

    // Backpressure on byte 4
    runStream("stall", randomMatrix(), 1, 1'b0, -1);

    // Shadow isolation with c_flat churn and start toggling
    runStream("shadow", randomMatrix(), 0, 1'b1, -1);

    // Reset after the 10th transfer, then a full replay
    mat = randomMatrix();
    runStream("abort", mat, 0, 1'b0, 10);
    runStream("replay", mat, 0, 1'b0, -1);

    // Random matrices with random backpressure
    for (int r = 0; r < 3; r++) begin
      runStream($sformatf("rand%0d", r), randomMatrix(), 2, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
